// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/response bundle for the iterative multiply/divide unit.
// master = requester side, slave = the alu_muldiv block.
interface alu_muldiv_if #(parameter int BW = 32);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [BW-1:0] d1;
    logic [BW-1:0] d2;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] res;
    logic          busy;

    modport master (
        output flush, in_valid, op, d1, d2, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  flush, in_valid, op, d1, d2, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: bit-serial multiply / divide unit (one result bit per cycle).
//   op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
// Operands are reduced to magnitudes at accept; signs are reapplied on the
// last iteration so the result register is loaded as the FSM enters DONE.
// Optional macro MULDIV_EARLY_OUT_EN: trivial zero-operand cases bypass
// the iteration and go IDLE->DONE on the accept edge.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   CALC  | iterating, one bit per cycle for BW cycles
//   DONE  | res valid, waiting for out_ready
module alu_muldiv #(
    parameter int BW = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_muldiv_if.slave bus
);

    localparam int CW = $clog2(BW);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [BW-1:0]   r_a;        // multiplicand or divisor magnitude
    logic [2*BW-1:0] r_acc;      // {product} or {remainder, quotient}
    logic            r_neg;      // product / quotient must be negated
    logic            r_neg_r;    // remainder must be negated
    logic [BW-1:0]   r_res;

    logic            w_accept;
    logic            w_last;
    logic            w_sgn1;
    logic            w_sgn2;
    logic            w_neg1;
    logic            w_neg2;
    logic [BW-1:0]   w_mag1;
    logic [BW-1:0]   w_mag2;
    logic [BW:0]     w_mul_sum;
    logic [2*BW-1:0] w_mul_nxt;
    logic [BW:0]     w_div_sh;
    logic [BW:0]     w_div_diff;
    logic [2*BW-1:0] w_div_nxt;
    logic [2*BW-1:0] w_acc_nxt;
    logic [2*BW-1:0] w_prod;
    logic [BW-1:0]   w_qmag;
    logic [BW-1:0]   w_rmag;
    logic [BW-1:0]   w_quot;
    logic [BW-1:0]   w_rem;
    logic [BW-1:0]   w_res_calc;

    assign w_accept = bus.in_valid && (r_state == S_IDLE) && !bus.flush;
    assign w_last   = (r_state == S_CALC) && (r_cnt == CW'(BW - 1));

    // d1 is signed for MULH, MULHSU, DIV, REM; d2 for MULH, DIV, REM
    assign w_sgn1 = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign w_sgn2 = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign w_neg1 = w_sgn1 && bus.d1[BW-1];
    assign w_neg2 = w_sgn2 && bus.d2[BW-1];
    assign w_mag1 = w_neg1 ? -bus.d1 : bus.d1;
    assign w_mag2 = w_neg2 ? -bus.d2 : bus.d2;

    // multiply step: add multiplicand to the upper half when the LSB is set, shift right
    assign w_mul_sum = {1'b0, r_acc[2*BW-1:BW]} + (r_acc[0] ? {1'b0, r_a} : {(BW+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[BW-1:1]};

    // restoring divide step: shift in next dividend bit, keep difference if non-negative
    assign w_div_sh   = r_acc[2*BW-1:BW-1];
    assign w_div_diff = w_div_sh - {1'b0, r_a};
    assign w_div_nxt  = w_div_diff[BW] ? {w_div_sh[BW-1:0], r_acc[BW-2:0], 1'b0}
                                       : {w_div_diff[BW-1:0], r_acc[BW-2:0], 1'b1};

    assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

    // Sign correction. A magnitude quotient of all ones only arises from a
    // zero divisor (signed magnitudes never exceed 2^(BW-1)), and that case
    // must stay all ones, so it is not negated.
    assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_qmag = w_acc_nxt[BW-1:0];
    assign w_rmag = w_acc_nxt[2*BW-1:BW];
    assign w_quot = (r_neg && !(&w_qmag)) ? -w_qmag : w_qmag;
    assign w_rem  = r_neg_r ? -w_rmag : w_rmag;

    // select the output field for the finishing iteration
    always_comb begin
        w_res_calc = w_rem;
        case (r_op)
            3'd0:             w_res_calc = w_prod[BW-1:0];
            3'd1, 3'd2, 3'd3: w_res_calc = w_prod[2*BW-1:BW];
            3'd4, 3'd5:       w_res_calc = w_quot;
            default:          w_res_calc = w_rem;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic          w_early;
    logic [BW-1:0] w_res_early;

    assign w_early     = bus.op[2] ? (bus.d2 == '0) : ((bus.d1 == '0) || (bus.d2 == '0));
    assign w_res_early = !bus.op[2] ? '0 : (bus.op[1] ? bus.d1 : '1);
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
`ifdef MULDIV_EARLY_OUT_EN
                        w_state_nxt = w_early ? S_DONE : S_CALC;
`else
                        w_state_nxt = S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (r_cnt == CW'(BW - 1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.busy      = (r_state != S_IDLE);
        bus.out_valid = (r_state == S_DONE);
    end

    assign bus.res = r_res;

    // datapath: operand capture on accept, one iteration per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_neg_r <= 1'b0;
            r_res   <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= bus.op;
            r_a     <= bus.op[2] ? w_mag2 : w_mag1;
            r_acc   <= {{BW{1'b0}}, (bus.op[2] ? w_mag1 : w_mag2)};
            r_neg   <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
                r_res <= w_res_early;
            end
`endif
        end else if ((r_state == S_CALC) && !bus.flush) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_res <= w_res_calc;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized and directed stimulus for alu_muldiv (BW=32),
// checked against a plain-arithmetic reference model.
module tb_alu_muldiv;

    localparam int BW = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = BW + 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_muldiv_if #(.BW(BW)) bus();

    alu_muldiv #(.BW(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          failures = 0;
    int          ecnt = 0;
    int          acc_edge = 0;
    logic        pend = 1'b0;
    logic [31:0] exp_res = '0;
    logic [31:0] last_res = '0;
    int          exp_lat = 0;
    logic        prev_ov = 1'b0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        sa = a;
        sb = b;
        ea = {32'b0, a};
        eb = {32'b0, b};
        case (o)
            3'd0: begin p = ea * eb; return p[31:0]; end
            3'd1: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; p = ea * eb; return p[63:32]; end
            3'd2: begin ea = {{32{a[31]}}, a}; p = ea * eb; return p[63:32]; end
            3'd3: begin p = ea * eb; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic z;
        z = o[2] ? (b == 0) : ((a == 0) || (b == 0));
        return z ? EARLY_LAT : BW + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // compare process: result, latency and handshake invariants every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            chk("busy_vs_in_ready", 32'(bus.busy), 32'(!bus.in_ready));
            if (bus.out_valid && !prev_ov) begin
                chk("valid_expected", 32'(pend), 32'd1);
                chk("res", bus.res, exp_res);
                chk("latency", ecnt - acc_edge + 1, exp_lat);
            end else if (bus.out_valid) begin
                chk("res_hold", bus.res, exp_res);
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_seen", 32'(bus.in_ready), 32'd1);
        bus.op = o;
        bus.d1 = a;
        bus.d2 = b;
        bus.in_valid = 1'b1;
        exp_res = model(o, a, b);
        exp_lat = lat_of(o, a, b);
        pend = 1'b1;
        @(posedge clk); #1;
        acc_edge = ecnt;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom);
        bus.d1 = $urandom;
        bus.d2 = $urandom;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        int n;
        start_op(o, a, b);
        n = 0;
        while (!bus.out_valid && n < BW + 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        chk("valid_before_consume", 32'(bus.out_valid), 32'd1);
        // a request offered in the consume cycle must not be taken
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        pend = 1'b0;
        last_res = exp_res;
        chk("valid_drop", 32'(bus.out_valid), 32'd0);
        chk("in_ready_after", 32'(bus.in_ready), 32'd1);
        chk("res_kept", bus.res, last_res);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = 3'd0;
        bus.d1 = '0;
        bus.d2 = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_res", bus.res, 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // pin the model with hand-computed values
        chk("m_mul", model(3'd0, 32'hFFFF_FFFF, 32'h2), 32'hFFFF_FFFE);
        chk("m_mulh", model(3'd1, 32'hFFFF_FFFF, 32'h2), 32'hFFFF_FFFF);
        chk("m_mulhu", model(3'd3, 32'hFFFF_FFFF, 32'h2), 32'h0000_0001);
        chk("m_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("m_div", model(3'd4, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
        chk("m_rem", model(3'd6, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
        chk("m_divu", model(3'd5, 32'd100, 32'd7), 32'd14);
        chk("m_remu", model(3'd7, 32'd100, 32'd7), 32'd2);
        chk("m_div_ovf", model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("m_rem_ovf", model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
        chk("m_divu_0", model(3'd5, 32'd5, 32'd0), 32'hFFFF_FFFF);
        chk("m_remu_0", model(3'd7, 32'd5, 32'd0), 32'd5);

        // directed cases
        run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 10);
        run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'h2, 1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'h2, 2);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'd5, 32'd0, 3);
        run_op(3'd7, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(3'd0, 32'd0, 32'h1234_5678, 0);

        // flush together with a request in IDLE: nothing accepted
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_blocks_accept", 32'(bus.in_ready), 32'd1);

        // flush five cycles into CALC
        start_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("calc_busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        pend = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_idle", 32'(bus.in_ready), 32'd1);
        chk("flush_no_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_res_kept", bus.res, last_res);
        repeat (BW + 5) begin
            @(posedge clk); #1;
        end
        chk("flush_still_quiet", 32'(bus.out_valid), 32'd0);
        run_op(3'd3, 32'd3, 32'd5, 0);

        // asynchronous reset between edges in the middle of CALC
        start_op(3'd5, 32'hDEAD_BEEF, 32'd13);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        pend = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_res", bus.res, 32'd0);
        last_res = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
